dlfloat_operand_sequencer: RTL

- Upstream feeder for the DLFloat16 MAC datapath. Accepts a stream of 16-bit DLFloat words with a valid/ready handshake and pairs consecutive words into operand A (first) and operand B (second).
- Buffers the pairs in a small FIFO and presents them to the MAC with a valid/ready handshake.
- Also provides accumulator-clear sequencing, a pair counter and a sticky NaN flag (word 16'hFFFF).

---
 rtl/dlfloat_operand_sequencer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/dlfloat_operand_sequencer.sv
// Pairs consecutive DLFloat16 words into {A,B} operands, queues them in a small
// FIFO for the MAC, and tracks accumulator clears, issued pairs and NaN words.
module dlfloat_operand_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      out_a,
  output logic [15:0]      out_b,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clear_req,
  output logic             acc_clear,
  output logic [CNT_W-1:0] pair_count,
  output logic             nan_seen,
  output logic             held_a
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {WAIT_A, WAIT_B} state_t;

  state_t           r_state, w_state_nxt;
  logic [15:0]      r_a_hold;
  logic [15:0]      r_mem_a [DEPTH];
  logic [15:0]      r_mem_b [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_acc_clear;
  logic [CNT_W-1:0] r_pair_count;
  logic             r_nan_seen;

  logic w_accept, w_push, w_pop, w_empty;

  // Ready depends only on registered state so out_ready never reaches in_ready.
  assign in_ready = (r_state == WAIT_A) | (r_count < FULL);
  assign w_accept = in_valid & in_ready & ~clear_req;
  assign w_push   = w_accept & (r_state == WAIT_B);
  assign w_empty  = (r_count == '0);
  assign w_pop    = ~w_empty & out_ready & ~clear_req;

  assign out_valid  = ~w_empty;
  assign out_a      = w_empty ? '0 : r_mem_a[r_rd_ptr];
  assign out_b      = w_empty ? '0 : r_mem_b[r_rd_ptr];
  assign held_a     = (r_state == WAIT_B);
  assign acc_clear  = r_acc_clear;
  assign pair_count = r_pair_count;
  assign nan_seen   = r_nan_seen;

  always_comb begin
    w_state_nxt = r_state;
    if (clear_req) begin
      w_state_nxt = WAIT_A;
    end else if (w_accept) begin
      w_state_nxt = (r_state == WAIT_A) ? WAIT_B : WAIT_A;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_A;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= r_a_hold;
      r_mem_b[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_hold     <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_acc_clear  <= 1'b0;
      r_pair_count <= '0;
      r_nan_seen   <= 1'b0;
    end else begin
      r_acc_clear <= clear_req;
      if (clear_req) begin
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_count      <= '0;
        r_pair_count <= '0;
        r_nan_seen   <= 1'b0;
      end else begin
        if (w_accept && (r_state == WAIT_A)) begin
          r_a_hold <= in_data;
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
          if (r_pair_count != '1) begin
            r_pair_count <= r_pair_count + CNT_W'(1);
          end
        end
        unique case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
        if (w_accept && (in_data == 16'hFFFF)) begin
          r_nan_seen <= 1'b1;
        end
      end
    end
  end

endmodule
